// File: rtl/bus_grant_rr8_if.sv
// Request/grant bundle between the eight requesters and the bus arbiter.
// Latency: none, wires only.
// Backpressure: requesters hold req until released via done, withdrawal or timeout.
interface bus_grant_rr8_if;
  logic [7:0] req;
  logic       done;
  logic       grant_valid;
  logic [2:0] grant_idx;
  logic [7:0] grant_onehot;
  logic       timeout;

  // Requester side: drives requests and the release strobe.
  modport master (
    output req,
    output done,
    input  grant_valid,
    input  grant_idx,
    input  grant_onehot,
    input  timeout
  );

  // Arbiter side: samples requests and drives the registered grant.
  modport slave (
    input  req,
    input  done,
    output grant_valid,
    output grant_idx,
    output grant_onehot,
    output timeout
  );
endinterface

// File: rtl/bus_grant_rr8.sv
// Round-robin owner selection for one shared bus among 8 requesters, with release and max-hold.
// Latency: grant registered one cycle after a sampled req; one turnaround cycle between owners.
// Backpressure: the owner keeps the bus until done, req withdrawal or MAX_HOLD cycles elapse.
module bus_grant_rr8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  bus_grant_rr8_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  // Last cycle index at which the current owner must be released; only used when the limit is on.
  localparam logic [7:0] HOLD_LAST = 8'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
  localparam bit         HOLD_EN   = (MAX_HOLD != 0);

  state_t     state_q, state_d;
  logic [2:0] last_idx_q, last_idx_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       grant_valid_q, grant_valid_d;
  logic [2:0] grant_idx_q, grant_idx_d;
  logic [7:0] grant_onehot_q, grant_onehot_d;
  logic       timeout_q, timeout_d;

  logic [2:0] pick_idx;
  logic       req_any;
  logic       rel_done;
  logic       rel_wd;
  logic       rel_to;

  assign req_any  = |bus.req;
  assign rel_done = bus.done;
  assign rel_wd   = ~bus.req[grant_idx_q];
  assign rel_to   = HOLD_EN && (hold_cnt_q == HOLD_LAST);

  // Round-robin search: scan from farthest to nearest after last_idx so the nearest set bit wins.
  always_comb begin
    pick_idx = last_idx_q;
    for (int k = 8; k >= 1; k--) begin
      if (bus.req[last_idx_q + 3'(k)]) begin
        pick_idx = last_idx_q + 3'(k);
      end
    end
  end

  // Next-state and registered-output computation; IDLE and TURN arbitrate identically.
  always_comb begin
    state_d        = state_q;
    last_idx_d     = last_idx_q;
    hold_cnt_d     = hold_cnt_q;
    grant_valid_d  = grant_valid_q;
    grant_idx_d    = grant_idx_q;
    grant_onehot_d = grant_onehot_q;
    timeout_d      = 1'b0;
    case (state_q)
      ST_IDLE, ST_TURN: begin
        state_d        = ST_IDLE;
        grant_valid_d  = 1'b0;
        grant_onehot_d = 8'd0;
        hold_cnt_d     = 8'd0;
        if (req_any) begin
          state_d        = ST_GRANT;
          grant_valid_d  = 1'b1;
          grant_idx_d    = pick_idx;
          grant_onehot_d = 8'd1 << pick_idx;
        end
      end
      ST_GRANT: begin
        if (rel_done || rel_wd || rel_to) begin
          state_d        = ST_TURN;
          last_idx_d     = grant_idx_q;
          grant_valid_d  = 1'b0;
          grant_onehot_d = 8'd0;
          // A voluntary release on the same edge suppresses the timeout pulse.
          timeout_d      = rel_to && !rel_done && !rel_wd;
        end else if (hold_cnt_q != 8'hFF) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears the grant immediately, even mid-ownership.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      last_idx_q     <= 3'd7;
      hold_cnt_q     <= 8'd0;
      grant_valid_q  <= 1'b0;
      grant_idx_q    <= 3'd0;
      grant_onehot_q <= 8'd0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_idx_q     <= last_idx_d;
      hold_cnt_q     <= hold_cnt_d;
      grant_valid_q  <= grant_valid_d;
      grant_idx_q    <= grant_idx_d;
      grant_onehot_q <= grant_onehot_d;
      timeout_q      <= timeout_d;
    end
  end

  assign bus.grant_valid  = grant_valid_q;
  assign bus.grant_idx    = grant_idx_q;
  assign bus.grant_onehot = grant_onehot_q;
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_bus_grant_rr8.sv
// Bench for bus_grant_rr8: directed and random req/done traffic against an ownership model.
// Latency: expected outputs are queued at each edge and compared at the following negedge.
// Backpressure: not applicable; requesters are driven directly by the bench.
module tb_bus_grant_rr8;

  localparam int MAXH = 16;

  logic clk;
  logic rst_n;

  bus_grant_rr8_if bif ();
  bus_grant_rr8_if bif0 ();

  bus_grant_rr8 #(.MAX_HOLD(MAXH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  bus_grant_rr8 #(.MAX_HOLD(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Ownership model: who owns the bus, for how many cycles, and who owned it last.
  int m_owner;
  int m_held;
  int m_last;
  bit m_tpulse;

  typedef struct packed {
    logic       vld;
    logic [2:0] idx;
    logic [7:0] oh;
    logic       to;
  } exp_t;

  exp_t exp_q[$];

  task automatic model_reset();
    m_owner  = -1;
    m_held   = 0;
    m_last   = 7;
    m_tpulse = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic d);
    if (m_owner >= 0) begin
      bit a, b, c;
      a = d;
      b = !r[m_owner];
      c = (MAXH != 0) && (m_held == MAXH);
      if (a || b || c) begin
        m_last   = m_owner;
        m_owner  = -1;
        m_tpulse = c && !a && !b;
      end else begin
        m_held++;
      end
    end else begin
      m_tpulse = 1'b0;
      if (r != 8'd0) begin
        for (int k = 1; k <= 8; k++) begin
          int j;
          j = (m_last + k) % 8;
          if (r[j]) begin
            m_owner = j;
            m_held  = 1;
            break;
          end
        end
      end
    end
  endtask

  task automatic push_expected();
    exp_t e;
    e.vld = (m_owner >= 0);
    e.idx = e.vld ? 3'(m_owner) : 3'd0;
    e.oh  = e.vld ? 8'(1 << m_owner) : 8'd0;
    e.to  = m_tpulse;
    exp_q.push_back(e);
  endtask

  // One bus cycle: apply inputs, let the edge sample them, record what must appear after it.
  task automatic cycle(input logic [7:0] r, input logic d);
    bif.req  = r;
    bif.done = d;
    @(posedge clk);
    model_step(r, d);
    push_expected();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(8'h00, 1'b0);
  endtask

  // Monitor: compare every presented output cycle against the oldest queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      exp_t a;
      e = exp_q.pop_front();
      a.vld = bif.grant_valid;
      a.idx = bif.grant_valid ? bif.grant_idx : 3'd0;
      a.oh  = bif.grant_onehot;
      a.to  = bif.timeout;
      check("grant_outputs{vld,idx,onehot,timeout}", 32'(a), 32'(e));
    end
  end

  // Assert reset away from the clock edge and verify the outputs clear without waiting for one.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_grant_valid", 32'(bif.grant_valid), 32'd0);
    check("rst_grant_idx", 32'(bif.grant_idx), 32'd0);
    check("rst_grant_onehot", 32'(bif.grant_onehot), 32'd0);
    check("rst_timeout", 32'(bif.timeout), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    logic       d;
    int         guard;
    int         cnt_vld;
    int         cnt_to;

    rst_n     = 1'b0;
    bif.req   = 8'h00;
    bif.done  = 1'b0;
    bif0.req  = 8'h00;
    bif0.done = 1'b0;
    model_reset();
    #3;
    check("init_grant_valid", 32'(bif.grant_valid), 32'd0);
    check("init_grant_idx", 32'(bif.grant_idx), 32'd0);
    check("init_grant_onehot", 32'(bif.grant_onehot), 32'd0);
    check("init_timeout", 32'(bif.timeout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Requester 0 has first priority out of reset.
    cycle(8'h01, 1'b0);
    cycle(8'h01, 1'b0);
    cycle(8'h01, 1'b1);
    idle(2);

    // Fairness: everybody requests, owner releases immediately.
    for (int i = 0; i < 20; i++) cycle(8'hFF, 1'b1);
    idle(2);

    // Sparse wrap: owner 6, then {5,0} requesting -> 0 before 5.
    cycle(8'h40, 1'b0);
    cycle(8'h40, 1'b0);
    cycle(8'h40, 1'b1);
    cycle(8'h21, 1'b0);
    cycle(8'h21, 1'b0);
    cycle(8'h21, 1'b1);
    cycle(8'h21, 1'b0);
    cycle(8'h21, 1'b1);
    idle(2);

    // Timeout: a lone holder is cut off after MAXH cycles and then re-granted.
    for (int i = 0; i < 40; i++) cycle(8'h08, 1'b0);
    idle(2);

    // Withdraw: owner 2 drops its request while 4 is waiting.
    for (int i = 0; i < 4; i++) cycle(8'h04, 1'b0);
    for (int i = 0; i < 4; i++) cycle(8'h10, 1'b0);
    idle(2);

    // Coincidence: done arrives on the same edge the hold limit expires.
    for (int i = 0; i < 45; i++) cycle(8'h08, (m_owner == 3) && (m_held == MAXH));
    idle(2);

    // Reset in the middle of a grant of requester 5.
    guard = 0;
    while (!(m_owner == 5 && m_held >= 3) && guard < 20) begin
      cycle(8'h20, 1'b0);
      guard++;
    end
    check("reached_owner5_grant", 32'(m_owner == 5), 32'd1);
    do_reset();
    cycle(8'h01, 1'b0);
    cycle(8'h01, 1'b0);
    idle(2);

    // Random traffic with mostly stable request patterns so timeouts also occur.
    r = 8'h00;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 7) == 0) r = 8'($urandom) & 8'($urandom);
      d = ($urandom_range(0, 5) == 0);
      cycle(r, d);
    end
    idle(2);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // Unlimited hold: a 300-cycle ownership is never cut off.
    bif0.req = 8'h10;
    @(posedge clk);
    cnt_vld = 0;
    cnt_to  = 0;
    for (int i = 0; i < 310; i++) begin
      @(negedge clk);
      if (bif0.grant_valid && bif0.grant_idx == 3'd4) cnt_vld++;
      if (bif0.timeout) cnt_to++;
    end
    check("nolimit_held_cycles", 32'(cnt_vld), 32'd310);
    check("nolimit_timeouts", 32'(cnt_to), 32'd0);
    check("nolimit_onehot", 32'(bif0.grant_onehot), 32'h10);
    bif0.req = 8'h00;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
